// File: rtl/xfcp_mm_initiator.sv
// XFCP memory-access requester: turns single-word read/write commands into XFCP
// request packets on an 8-bit stream and parses the matching response packet.
module xfcp_mm_initiator #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic [7:0]            m_xfcp_tdata,
  output logic                  m_xfcp_tvalid,
  output logic                  m_xfcp_tlast,
  output logic                  m_xfcp_tuser,
  input  logic                  m_xfcp_tready,
  input  logic [7:0]            s_xfcp_tdata,
  input  logic                  s_xfcp_tvalid,
  input  logic                  s_xfcp_tlast,
  input  logic                  s_xfcp_tuser,
  output logic                  s_xfcp_tready
);

  localparam int unsigned AddrBytes = ADDR_WIDTH / 8;
  localparam int unsigned DataBytes = DATA_WIDTH / 8;
  localparam int unsigned WideW     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned ShW       = (WideW > 16) ? WideW : 16;
  localparam int unsigned CntW      = $clog2(ShW / 8);
  localparam int unsigned TmoW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CntW-1:0] AddrLast  = CntW'(AddrBytes - 1);
  localparam logic [CntW-1:0] LenLast   = CntW'(1);
  localparam logic [CntW-1:0] DataLast  = CntW'(DataBytes - 1);
  localparam logic [15:0]     LenVal    = 16'(DataBytes);
  localparam logic [TmoW-1:0] TmoLoad   = TmoW'(TIMEOUT);
  localparam logic [7:0]      TypeRdReq = 8'h10;
  localparam logic [7:0]      TypeWrReq = 8'h12;
  localparam logic [7:0]      TypeRdRsp = 8'h11;
  localparam logic [7:0]      TypeWrRsp = 8'h13;

  typedef enum logic [3:0] {
    StIdle, StTxType, StTxAddr, StTxLen, StTxData,
    StRxType, StRxAddr, StRxLen, StRxData, StRxDrop, StRsp
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ShW-1:0]          sh_q, sh_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              err_q, err_d;
  logic                    bad_q, bad_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    rx_mism;

  // sh_q holds the field currently being sent or compared, LSB byte first.
  assign rx_mism      = (s_xfcp_tdata != sh_q[7:0]);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign m_xfcp_tuser = 1'b0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    bad_d   = bad_q;
    tmo_d   = tmo_q;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_xfcp_tvalid = 1'b0;
    m_xfcp_tlast  = 1'b0;
    m_xfcp_tdata  = sh_q[7:0];
    s_xfcp_tready = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          sh_d    = ShW'(cmd_addr);
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = '0;
          bad_d   = 1'b0;
          state_d = StTxType;
        end
      end
      StTxType: begin
        m_xfcp_tvalid = 1'b1;
        m_xfcp_tdata  = write_q ? TypeWrReq : TypeRdReq;
        if (m_xfcp_tready) state_d = StTxAddr;
      end
      StTxAddr: begin
        m_xfcp_tvalid = 1'b1;
        if (m_xfcp_tready) begin
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == AddrLast) begin
            cnt_d   = '0;
            sh_d    = ShW'(LenVal);
            state_d = StTxLen;
          end
        end
      end
      StTxLen: begin
        m_xfcp_tvalid = 1'b1;
        m_xfcp_tlast  = !write_q && (cnt_q == LenLast);
        if (m_xfcp_tready) begin
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LenLast) begin
            cnt_d = '0;
            if (write_q) begin
              sh_d    = ShW'(wdata_q);
              state_d = StTxData;
            end else begin
              sh_d    = ShW'(addr_q);
              tmo_d   = TmoLoad;
              state_d = StRxType;
            end
          end
        end
      end
      StTxData: begin
        m_xfcp_tvalid = 1'b1;
        m_xfcp_tlast  = (cnt_q == DataLast);
        if (m_xfcp_tready) begin
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DataLast) begin
            cnt_d   = '0;
            sh_d    = ShW'(addr_q);
            tmo_d   = TmoLoad;
            state_d = StRxType;
          end
        end
      end
      StRxType: begin
        s_xfcp_tready = 1'b1;
        if (s_xfcp_tvalid) begin
          if (s_xfcp_tlast) begin
            state_d = StRsp;
            err_d   = 2'b10;
          end else if (s_xfcp_tdata == (write_q ? TypeWrRsp : TypeRdRsp)) begin
            state_d = StRxAddr;
          end else begin
            state_d = StRxDrop;
          end
        end else if (TIMEOUT != 0) begin
          if (tmo_q == TmoW'(1)) begin
            state_d = StRsp;
            err_d   = 2'b01;
          end else begin
            tmo_d = tmo_q - TmoW'(1);
          end
        end
      end
      StRxAddr: begin
        s_xfcp_tready = 1'b1;
        if (s_xfcp_tvalid) begin
          bad_d = bad_q | rx_mism;
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + 1'b1;
          if (s_xfcp_tlast) begin
            state_d = StRsp;
            err_d   = 2'b10;
          end else if (cnt_q == AddrLast) begin
            cnt_d   = '0;
            sh_d    = ShW'(LenVal);
            state_d = StRxLen;
          end
        end
      end
      StRxLen: begin
        s_xfcp_tready = 1'b1;
        if (s_xfcp_tvalid) begin
          bad_d = bad_q | rx_mism;
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LenLast) begin
            cnt_d = '0;
            if (write_q) begin
              if (!s_xfcp_tlast) begin
                state_d = StRxDrop;
              end else begin
                state_d = StRsp;
                err_d   = (bad_q || rx_mism || s_xfcp_tuser) ? 2'b10 : 2'b00;
              end
            end else if (s_xfcp_tlast) begin
              state_d = StRsp;
              err_d   = 2'b10;
            end else begin
              state_d = StRxData;
            end
          end else if (s_xfcp_tlast) begin
            state_d = StRsp;
            err_d   = 2'b10;
          end
        end
      end
      StRxData: begin
        s_xfcp_tready = 1'b1;
        if (s_xfcp_tvalid) begin
          rdata_d = (rdata_q >> 8) | (DATA_WIDTH'(s_xfcp_tdata) << (DATA_WIDTH - 8));
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == DataLast) begin
            cnt_d = '0;
            if (!s_xfcp_tlast) begin
              state_d = StRxDrop;
            end else if (bad_q || s_xfcp_tuser) begin
              state_d = StRsp;
              err_d   = 2'b10;
              rdata_d = '0;
            end else begin
              state_d = StRsp;
            end
          end else if (s_xfcp_tlast) begin
            state_d = StRsp;
            err_d   = 2'b10;
            rdata_d = '0;
          end
        end
      end
      StRxDrop: begin
        s_xfcp_tready = 1'b1;
        if (s_xfcp_tvalid && s_xfcp_tlast) begin
          state_d = StRsp;
          err_d   = 2'b10;
          rdata_d = '0;
        end
      end
      StRsp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      bad_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
